// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read RAM port between instruction fetch and
//   load/store. One access is issued per cycle. Data requests win. The
//   registered response owner steers the read data that comes back one
//   cycle after the grant.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add a starvation guard.
//   In that build, fetch is forced to win after STARVE_LIMIT consecutive
//   denied fetch cycles.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   i_req/i_addr          : fetch read request
//   i_ready               : fetch granted this cycle
//   i_rvalid/i_rdata      : fetch read response (one cycle after grant)
//   d_req/d_we/d_addr/d_wdata : data request (read or write)
//   d_ready               : data granted this cycle
//   d_rvalid/d_rdata      : data read response (reads only)
//   mem_en/mem_we/mem_addr/mem_wdata : RAM access strobe and payload
//   mem_rdata             : RAM read data, valid the cycle after a read strobe
//   conflict_count        : saturating count of cycles with both requests high
module mem_port_arbiter #(
    parameter int ADDRESS_BITS = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDRESS_BITS-1:0] i_addr,
    output logic                    i_ready,
    output logic                    i_rvalid,
    output logic [31:0]             i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRESS_BITS-1:0] d_addr,
    input  logic [31:0]             d_wdata,
    output logic                    d_ready,
    output logic                    d_rvalid,
    output logic [31:0]             d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    output logic [15:0]             conflict_count
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IFETCH = 2'd1,
        OWN_DREAD  = 2'd2
    } owner_t;

    owner_t owner, owner_next;
    logic   force_fetch;
    logic   grant_i, grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;

    // Counts consecutive cycles where fetch asks but loses. It clears as soon
    // as fetch is served or stops asking. It stops counting at the limit, so
    // force_fetch holds until the grant happens.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!i_req || grant_i) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_fetch = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && i_req;
`else
    assign force_fetch = 1'b0;
`endif

    // Grant selection. Reset masks every grant, so the RAM sees no strobe
    // while the core is being reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (force_fetch) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    assign i_ready = grant_i;
    assign d_ready = grant_d;

    // The memory payload is muxed from the granted port. It is zero when
    // nothing is granted, so an idle port is quiet.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_i) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr;
        end
    end

    // Response owner: records who receives next cycle's mem_rdata.
    // A write leaves no owner because it completes at grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_next;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (grant_i) begin
            owner_next = OWN_IFETCH;
        end else if (grant_d && !d_we) begin
            owner_next = OWN_DREAD;
        end
    end

    // While reset is high, any response still in flight is suppressed.
    // All outputs therefore read 0 during reset.
    assign i_rvalid = !reset && (owner == OWN_IFETCH);
    assign d_rvalid = !reset && (owner == OWN_DREAD);
    assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (i_req && d_req && (conflict_count != 16'hFFFF)) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, i_ready, i_rvalid;
    logic [15:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_ready, d_rvalid;
    logic [15:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] conflict_count;

    int vectors = 0;
    int errs    = 0;

    logic [31:0] ram [0:1023];

    mem_port_arbiter #(.ADDRESS_BITS(16), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_count(conflict_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM model
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, apply inputs shortly after the edge, and let them settle
    task automatic step(input logic rst, input logic ir, input logic [15:0] ia,
                        input logic dr, input logic dw, input logic [15:0] da,
                        input logic [31:0] dwd);
        @(posedge clock);
        #1;
        reset = rst; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #2;
    endtask

    initial begin
        bit exp_fetch;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[16'h0004] = 32'h00500093;
        ram[16'h0008] = 32'h00A00113;
        ram[16'h0100] = 32'hDEADBEEF;

        reset = 1'b1; i_req = 1'b1; i_addr = 16'h0004;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 32'hFFFF0000;

        // Reset with both requests asserted: everything quiet
        step(1, 1, 16'h0004, 1, 1, 16'h0300, 32'hFFFF0000);
        step(1, 1, 16'h0004, 1, 1, 16'h0300, 32'hFFFF0000);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_conflict", conflict_count, 0);

        // Single fetch
        step(0, 1, 16'h0004, 0, 0, 16'h0000, 32'h0);
        chk("f1_i_ready", i_ready, 1);
        chk("f1_d_ready", d_ready, 0);
        chk("f1_mem_en", mem_en, 1);
        chk("f1_mem_addr", mem_addr, 16'h0004);
        chk("f1_mem_we", mem_we, 0);
        chk("f1_i_rvalid_c0", i_rvalid, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0);
        chk("f1_i_rvalid_c1", i_rvalid, 1);
        chk("f1_i_rdata_c1", i_rdata, 32'h00500093);
        chk("f1_d_rvalid_c1", d_rvalid, 0);
        chk("f1_idle_mem_en", mem_en, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0);
        chk("f1_i_rvalid_c2", i_rvalid, 0);
        chk("f1_i_rdata_gated", i_rdata, 0);

        // Conflict: data read wins, fetch is granted next cycle
        step(0, 1, 16'h0008, 1, 0, 16'h0100, 32'h0);
        chk("c_d_ready", d_ready, 1);
        chk("c_i_ready", i_ready, 0);
        chk("c_mem_addr", mem_addr, 16'h0100);
        step(0, 1, 16'h0008, 0, 0, 16'h0000, 32'h0);
        chk("c_d_rvalid", d_rvalid, 1);
        chk("c_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("c_i_rvalid", i_rvalid, 0);
        chk("c_i_ready_c1", i_ready, 1);
        chk("c_mem_addr_c1", mem_addr, 16'h0008);
        chk("c_conflict", conflict_count, 1);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0);
        chk("c_i_rvalid_c2", i_rvalid, 1);
        chk("c_i_rdata_c2", i_rdata, 32'h00A00113);
        chk("c_d_rvalid_c2", d_rvalid, 0);
        chk("c_d_rdata_gated", d_rdata, 0);

        // Write beats a pending fetch, then a read-back
        step(0, 1, 16'h0004, 1, 1, 16'h0200, 32'h12345678);
        chk("w_d_ready", d_ready, 1);
        chk("w_i_ready", i_ready, 0);
        chk("w_mem_we", mem_we, 1);
        chk("w_mem_addr", mem_addr, 16'h0200);
        chk("w_mem_wdata", mem_wdata, 32'h12345678);
        step(0, 0, 16'h0000, 1, 0, 16'h0200, 32'h0);
        chk("w_no_d_rvalid", d_rvalid, 0);
        chk("w_no_i_rvalid", i_rvalid, 0);
        chk("r_d_ready", d_ready, 1);
        chk("r_mem_we", mem_we, 0);
        chk("w_conflict", conflict_count, 2);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0);
        chk("r_d_rvalid", d_rvalid, 1);
        chk("r_d_rdata", d_rdata, 32'h12345678);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_wdata", mem_wdata, 0);

        // Both requests held for 10 cycles
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 16'h0004, 1, 0, 16'h0100, 32'h0);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_fetch = (k == 4) || (k == 9);
`else
            exp_fetch = 1'b0;
`endif
            chk($sformatf("s_i_ready_%0d", k), i_ready, exp_fetch);
            chk($sformatf("s_d_ready_%0d", k), d_ready, !exp_fetch);
            chk($sformatf("s_conflict_%0d", k), conflict_count, 2 + k);
        end
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0);
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("s_tail_i_rvalid", i_rvalid, 1);
        chk("s_tail_i_rdata", i_rdata, 32'h00500093);
`else
        chk("s_tail_d_rvalid", d_rvalid, 1);
        chk("s_tail_d_rdata", d_rdata, 32'hDEADBEEF);
`endif
        chk("s_tail_conflict", conflict_count, 12);

        // Reset while a fetch response is outstanding
        step(0, 1, 16'h0004, 0, 0, 16'h0000, 32'h0);
        chk("rr_i_ready", i_ready, 1);
        step(1, 1, 16'h0004, 1, 0, 16'h0100, 32'h0);
        chk("rr_i_rvalid_in_rst", i_rvalid, 0);
        chk("rr_i_rdata_in_rst", i_rdata, 0);
        chk("rr_i_ready_in_rst", i_ready, 0);
        chk("rr_d_ready_in_rst", d_ready, 0);
        chk("rr_mem_en_in_rst", mem_en, 0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0);
        chk("rr_i_rvalid_after", i_rvalid, 0);
        chk("rr_d_rvalid_after", d_rvalid, 0);
        chk("rr_conflict_after", conflict_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
